// File: rtl/rs_scheduler_if.sv
// Shared scheduler types plus the dispatch, completion and register-read
// interfaces for rs_scheduler.
package core_pkg;
    parameter int RS_ENTRIES = 8;
    parameter int NUM_FUS    = 4;
    parameter int NUM_PREGS  = 128;
    parameter int IW         = $clog2(RS_ENTRIES);
    parameter int DW         = RS_ENTRIES * NUM_FUS;
    parameter int PW         = $clog2(NUM_PREGS);

    typedef struct packed {
        logic [PW-1:0] dst_preg;
        logic [PW-1:0] src1_preg;
        logic [PW-1:0] src2_preg;
        logic [31:0]   imm_val;
        logic [31:0]   pc;
        logic          instr_valid;
    } disp_packet_t;
endpackage

interface sched_disp_if;
    import core_pkg::*;
    logic             disp_valid;
    disp_packet_t     disp_pkt;
    logic [DW-1:0]    dependency_mask;
    logic [IW-1:0]    rs_entry_idx;
    logic             rs_full;

    modport master (output disp_valid, disp_pkt, dependency_mask,
                    input  rs_entry_idx, rs_full);
    modport slave  (input  disp_valid, disp_pkt, dependency_mask,
                    output rs_entry_idx, rs_full);
endinterface

interface sched_exec_if;
    import core_pkg::*;
    logic          complete_valid;
    logic [IW-1:0] complete_idx;

    modport master (output complete_valid, complete_idx);
    modport slave  (input  complete_valid, complete_idx);
endinterface

interface sched_rr_if;
    import core_pkg::*;
    logic         fire_valid;
    disp_packet_t sched_pkt;

    modport master (output fire_valid, sched_pkt);
    modport slave  (input  fire_valid, sched_pkt);
endinterface

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: payload RAM, wakeup matrix, fixed-priority select.
// Define SCHED_ASSERT_EN to compile in simulation-only protocol assertions.
module rs_scheduler
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [RS_ENTRIES-1:0] local_ready_mask,
    input  logic [DW-1:0]         global_ready_mask,
    sched_disp_if.slave           disp_if,
    sched_exec_if.slave           exec_if,
    sched_rr_if.master            reg_read_if
);
    logic [RS_ENTRIES-1:0] entry_valid;
    logic [RS_ENTRIES-1:0] issued;
    logic [DW-1:0]         dep_row [RS_ENTRIES];
    disp_packet_t          payload_ram [RS_ENTRIES];

    logic [RS_ENTRIES-1:0] reqs_in;
    logic [RS_ENTRIES-1:0] reqs_out;
    logic [RS_ENTRIES-1:0] grant_oh;
    logic [IW-1:0]         grant_idx;
    logic                  grant_valid;
    logic [IW-1:0]         alloc_idx;
    logic                  alloc_found;
    logic                  rs_full;
    logic                  disp_accept;

    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (!entry_valid[i] && !alloc_found) begin
                alloc_idx   = IW'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign rs_full              = &entry_valid;
    assign disp_if.rs_full      = rs_full;
    assign disp_if.rs_entry_idx = alloc_idx;
    assign disp_accept          = disp_if.disp_valid && !rs_full;

    always_comb begin
        reqs_in = '0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++)
            reqs_in[i] = entry_valid[i] & ~issued[i] & (dep_row[i] == '0);
    end

    // Lowest index wins; grant_oh is recovered as the bit removed from reqs_out.
    always_comb begin
        reqs_out    = reqs_in;
        grant_idx   = '0;
        grant_valid = |reqs_in;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (reqs_in[i] && (reqs_out == reqs_in)) begin
                reqs_out[i] = 1'b0;
                grant_idx   = IW'(i);
            end
        end
        grant_oh = reqs_in ^ reqs_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid             <= '0;
            issued                  <= '0;
            local_ready_mask        <= '0;
            reg_read_if.fire_valid  <= 1'b0;
            reg_read_if.sched_pkt   <= '0;
            for (int unsigned i = 0; i < RS_ENTRIES; i++)
                dep_row[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < RS_ENTRIES; i++)
                dep_row[i] <= dep_row[i] & ~global_ready_mask;
            issued <= issued | grant_oh;
            if (disp_accept) begin
                entry_valid[alloc_idx] <= 1'b1;
                issued[alloc_idx]      <= 1'b0;
                dep_row[alloc_idx]     <= disp_if.dependency_mask & ~global_ready_mask;
            end
            // Dealloc is last so it wins over a same-cycle grant on that entry.
            if (exec_if.complete_valid) begin
                entry_valid[exec_if.complete_idx] <= 1'b0;
                issued[exec_if.complete_idx]      <= 1'b0;
            end
            reg_read_if.fire_valid <= grant_valid;
            local_ready_mask       <= grant_oh;
            if (grant_valid)
                reg_read_if.sched_pkt <= payload_ram[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && disp_accept)
            payload_ram[alloc_idx] <= disp_if.disp_pkt;
    end

`ifdef SCHED_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(disp_if.disp_valid && rs_full))
                else $error("rs_scheduler: dispatch while full");
            assert ($onehot0(local_ready_mask))
                else $error("rs_scheduler: local_ready_mask not one-hot");
            if (exec_if.complete_valid)
                assert (entry_valid[exec_if.complete_idx] && issued[exec_if.complete_idx])
                    else $error("rs_scheduler: complete on invalid or unissued entry");
        end
    end
`endif
endmodule

// File: tb/tb_rs_scheduler.sv
// Directed bench for rs_scheduler with a fire scoreboard checked on every tick.
module tb_rs_scheduler;
    import core_pkg::*;

    typedef struct {
        disp_packet_t          pkt;
        logic [RS_ENTRIES-1:0] oh;
    } sb_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [RS_ENTRIES-1:0] local_ready_mask;
    logic [DW-1:0]         global_ready_mask;
    int                    checks   = 0;
    int                    failures = 0;
    sb_t                   sb [$];

    sched_disp_if disp_if ();
    sched_exec_if exec_if ();
    sched_rr_if   rr_if ();

    rs_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .local_ready_mask  (local_ready_mask),
        .global_ready_mask (global_ready_mask),
        .disp_if           (disp_if),
        .exec_if           (exec_if),
        .reg_read_if       (rr_if)
    );

    always #5 clk = ~clk;

    function automatic disp_packet_t mk(input int dst, input int s1, input int s2,
                                        input logic [31:0] imm, input logic [31:0] pc);
        disp_packet_t p;
        p.dst_preg    = PW'(dst);
        p.src1_preg   = PW'(s1);
        p.src2_preg   = PW'(s2);
        p.imm_val     = imm;
        p.pc          = pc;
        p.instr_valid = 1'b1;
        return p;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and score any fire against the expected queue.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        @(negedge clk);
        if (rr_if.fire_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_fire", 128'(local_ready_mask), 128'(0));
            end else begin
                e = sb.pop_front();
                check("fire_pkt", 128'(rr_if.sched_pkt), 128'(e.pkt));
                check("fire_mask", 128'(local_ready_mask), 128'(e.oh));
            end
        end else begin
            check("idle_mask", 128'(local_ready_mask), 128'(0));
        end
    endtask

    task automatic do_reset();
        rst                     = 1'b1;
        disp_if.disp_valid      = 1'b0;
        disp_if.disp_pkt        = '0;
        disp_if.dependency_mask = '0;
        exec_if.complete_valid  = 1'b0;
        exec_if.complete_idx    = '0;
        global_ready_mask       = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic dispatch(input disp_packet_t p, input logic [DW-1:0] deps);
        disp_if.disp_valid      = 1'b1;
        disp_if.disp_pkt        = p;
        disp_if.dependency_mask = deps;
    endtask

    initial begin
        sb_t e;
        logic [RS_ENTRIES-1:0] oh;

        do_reset();
        check("rst_fire_valid", 128'(rr_if.fire_valid), 128'(0));
        check("rst_ready_mask", 128'(local_ready_mask), 128'(0));
        check("rst_sched_pkt", 128'(rr_if.sched_pkt), 128'(0));
        check("rst_full", 128'(disp_if.rs_full), 128'(0));
        check("rst_idx", 128'(disp_if.rs_entry_idx), 128'(0));

        // Single op, no dependencies: fires two edges after dispatch, once.
        dispatch(mk(10, 20, 30, 32'h0, 32'h1000), '0);
        e.pkt = mk(10, 20, 30, 32'h0, 32'h1000); e.oh = 8'h01; sb.push_back(e);
        tick();
        disp_if.disp_valid = 1'b0;
        check("e0_valid", 128'(dut.entry_valid[0]), 128'(1));
        check("e0_dst", 128'(dut.payload_ram[0].dst_preg), 128'(10));
        check("e0_req", 128'(dut.reqs_in[0]), 128'(1));
        check("e0_fire_lat", 128'(rr_if.fire_valid), 128'(0));
        check("idx_after_e0", 128'(disp_if.rs_entry_idx), 128'(1));
        tick();
        check("e0_fired", 128'(rr_if.fire_valid), 128'(1));
        check("e0_reqs_out", 128'(dut.reqs_out[0]), 128'(0));
        tick();
        tick();
        check("e0_single_fire", 128'(sb.size()), 128'(0));

        // Two outstanding producers woken one at a time.
        dispatch(mk(15, 1, 2, 32'h5, 32'h1004), 32'h3);
        tick();
        disp_if.disp_valid = 1'b0;
        check("e1_blocked", 128'(dut.reqs_in[1]), 128'(0));
        global_ready_mask = 32'h1;
        tick();
        check("e1_row_partial", 128'(dut.dep_row[1]), 128'(32'h2));
        check("e1_still_blocked", 128'(dut.reqs_in[1]), 128'(0));
        global_ready_mask = 32'h3;
        e.pkt = mk(15, 1, 2, 32'h5, 32'h1004); e.oh = 8'h02; sb.push_back(e);
        tick();
        global_ready_mask = '0;
        check("e1_row_clear", 128'(dut.dep_row[1]), 128'(0));
        check("e1_req", 128'(dut.reqs_in[1]), 128'(1));
        tick();
        check("e1_fired", 128'(rr_if.fire_valid), 128'(1));

        // Producer firing in the dispatch cycle is applied to the incoming mask.
        dispatch(mk(40, 3, 4, 32'h9, 32'h1008), 32'h20);
        global_ready_mask = 32'h20;
        e.pkt = mk(40, 3, 4, 32'h9, 32'h1008); e.oh = 8'h04; sb.push_back(e);
        tick();
        disp_if.disp_valid = 1'b0;
        global_ready_mask  = '0;
        check("e2_row_bypass", 128'(dut.dep_row[2]), 128'(0));
        tick();
        tick();
        check("wake_drain", 128'(sb.size()), 128'(0));

        // Fill the station, then try one more dispatch.
        do_reset();
        for (int i = 0; i < RS_ENTRIES; i++) begin
            dispatch(mk(i + 1, i + 2, i + 3, 32'(i), 32'h2000 + 32'(i * 4)), '0);
            oh = '0; oh[i] = 1'b1;
            e.pkt = mk(i + 1, i + 2, i + 3, 32'(i), 32'h2000 + 32'(i * 4)); e.oh = oh;
            sb.push_back(e);
            tick();
        end
        disp_if.disp_valid = 1'b0;
        check("fill_valid", 128'(dut.entry_valid), 128'({RS_ENTRIES{1'b1}}));
        check("fill_full", 128'(disp_if.rs_full), 128'(1));
        tick();
        dispatch(mk(99, 0, 0, 32'h0, 32'hDEAD), '0);
        tick();
        disp_if.disp_valid = 1'b0;
        check("full_drop_valid", 128'($countones(dut.entry_valid)), 128'(RS_ENTRIES));
        check("full_drop_full", 128'(disp_if.rs_full), 128'(1));
        check("full_drop_e0", 128'(dut.payload_ram[0].dst_preg), 128'(1));
        tick();
        check("fill_drain", 128'(sb.size()), 128'(0));

        // Free a middle entry and refill it.
        exec_if.complete_valid = 1'b1;
        exec_if.complete_idx   = 3'd3;
        tick();
        exec_if.complete_valid = 1'b0;
        check("dealloc_full", 128'(disp_if.rs_full), 128'(0));
        check("dealloc_idx", 128'(disp_if.rs_entry_idx), 128'(3));
        dispatch(mk(77, 5, 6, 32'h7, 32'h3000), '0);
        e.pkt = mk(77, 5, 6, 32'h7, 32'h3000); e.oh = 8'h08; sb.push_back(e);
        tick();
        disp_if.disp_valid = 1'b0;
        check("refill_full", 128'(disp_if.rs_full), 128'(1));
        tick();
        tick();
        check("refill_drain", 128'(sb.size()), 128'(0));

        // Payload integrity across three back-to-back dispatches.
        do_reset();
        dispatch(mk(6, 7, 8, 32'h11, 32'hA000), '0);
        e.pkt = mk(6, 7, 8, 32'h11, 32'hA000); e.oh = 8'h01; sb.push_back(e);
        tick();
        dispatch(mk(16, 17, 18, 32'h22, 32'hB000), '0);
        e.pkt = mk(16, 17, 18, 32'h22, 32'hB000); e.oh = 8'h02; sb.push_back(e);
        tick();
        dispatch(mk(26, 27, 28, 32'h33, 32'hC000), '0);
        e.pkt = mk(26, 27, 28, 32'h33, 32'hC000); e.oh = 8'h04; sb.push_back(e);
        tick();
        disp_if.disp_valid = 1'b0;
        check("pay_e0_dst", 128'(dut.payload_ram[0].dst_preg), 128'(6));
        check("pay_e1_dst", 128'(dut.payload_ram[1].dst_preg), 128'(16));
        check("pay_e2_dst", 128'(dut.payload_ram[2].dst_preg), 128'(26));
        check("pay_e0_pc", 128'(dut.payload_ram[0].pc), 128'(32'hA000));
        check("pay_e1_imm", 128'(dut.payload_ram[1].imm_val), 128'(32'h22));
        tick();
        tick();
        check("final_drain", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
